// File: rtl/sw_press_decoder.sv
// ---------------------------------------------------------------------------
// sw_press_decoder
//
// Turns four raw, bouncing slide/push switch levels into clean single-press
// events for the game FSM. A press is accepted only when exactly one switch
// has been stable for DB_CYCLES clocks while input is enabled. The press is
// then reported once, and the switches must be released (and the release
// debounced) before another press can count.
//
// Optional feature macro: SW_MULTI_PRESS_ERR_EN
//   defined   -> a debounced multi-switch pattern pulses err for one cycle
//   undefined -> err is held at 0 and multi-switch patterns are ignored
//
// Ports:
//   clk          system clock (CLOCK_50 at top level)
//   reset        synchronous, active-high reset
//   on_off       high while the game FSM accepts player input
//   sw[3:0]      raw asynchronous switch levels
//   press_valid  one-cycle pulse: debounced single-switch press
//   press_code   index of pressed switch, held until the next press_valid
//   busy         high whenever the FSM is not in IDLE
//   err          one-cycle pulse: debounced multi-switch press
// ---------------------------------------------------------------------------
module sw_press_decoder #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       on_off,
  input  logic [3:0] sw,
  output logic       press_valid,
  output logic [1:0] press_code,
  output logic       busy,
  output logic       err
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [3:0]       pat, pat_next;
  logic [3:0]       sw_p0, sw_p1;
  logic [3:0]       ss;
  logic             pv_next, err_next;
  logic [1:0]       code_next;

  function automatic logic is_one_hot(input logic [3:0] p);
    return (p != 4'd0) && ((p & (p - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] hot_index(input logic [3:0] p);
    logic [1:0] idx;
    idx = 2'd0;
    case (p)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Stage p0/p1: two-flop synchronizer; everything downstream uses ss only.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_p0 <= 4'd0;
      sw_p1 <= 4'd0;
    end else begin
      sw_p0 <= sw;
      sw_p1 <= sw_p0;
    end
  end

  assign ss = sw_p1;

  // FSM next-state and registered-output logic.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pat_next   = pat;
    code_next  = press_code;
    pv_next    = 1'b0;
    err_next   = 1'b0;

    if (!on_off) begin
      // Disabling input parks the FSM in HELD so switches still down at
      // re-enable have to be released and debounced first.
      state_next = HELD;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (ss != 4'd0) begin
            state_next = DB_PRESS;
            pat_next   = ss;
            cnt_next   = '0;
          end
        end

        DB_PRESS: begin
          if (ss == 4'd0) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else if (ss != pat) begin
            // Pattern changed while bouncing: restart the stable-time window.
            pat_next = ss;
            cnt_next = '0;
          end else if (cnt == CNT_LAST) begin
            state_next = HELD;
            cnt_next   = '0;
            if (is_one_hot(pat)) begin
              pv_next   = 1'b1;
              code_next = hot_index(pat);
            end else begin
`ifdef SW_MULTI_PRESS_ERR_EN
              err_next = 1'b1;
`else
              err_next = 1'b0;
`endif
            end
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end

        HELD: begin
          if (ss == 4'd0) begin
            state_next = DB_RELEASE;
            cnt_next   = '0;
          end
        end

        DB_RELEASE: begin
          if (ss != 4'd0) begin
            state_next = HELD;
            cnt_next   = '0;
          end else if (cnt == CNT_LAST) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end

        default: begin
          state_next = HELD;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HELD;
      cnt         <= '0;
      pat         <= 4'd0;
      press_valid <= 1'b0;
      press_code  <= 2'd0;
      err         <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      pat         <= pat_next;
      press_valid <= pv_next;
      press_code  <= code_next;
      err         <= err_next;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/sw_press_decoder.md
SW_PRESS_DECODER -- requirements
Module: sw_press_decoder

Interface
REQ-001 Parameter DB_CYCLES, default 1_000_000, debounce stable-time in clk cycles; legal range >= 2.
REQ-002 clk  input  1  system clock (CLOCK_50 at top level).
REQ-003 reset  input  1  synchronous, active-high reset; one clock, all state on rising edge of clk.
REQ-004 on_off  input  1  enable from game fsm; high while player input is accepted.
REQ-005 sw  input  4  raw, asynchronous, bouncing switch levels (SW[3:0]).
REQ-006 press_valid  output  1  one-cycle pulse: one debounced single-switch press detected.
REQ-007 press_code  output  2  index of pressed switch; valid with press_valid, held until next press_valid.
REQ-008 busy  output  1  high whenever FSM is not in IDLE.
REQ-009 err  output  1  one-cycle pulse: debounced multi-switch press (see Configuration).

Function
REQ-010 sw SHALL pass through a 2-flop synchronizer; all further logic uses synced value ss only.
REQ-011 FSM states: IDLE, DB_PRESS, HELD, DB_RELEASE; 2-bit encoding.
REQ-012 IDLE: ss != 0 and on_off=1 -> DB_PRESS, capture ss into pat, cnt := 0.
REQ-013 DB_PRESS: ss == pat -> cnt++; ss == 0 -> IDLE; ss nonzero != pat -> recapture pat, cnt := 0, stay.
REQ-014 DB_PRESS with ss == pat and cnt == DB_CYCLES-1: pat one-hot -> press_valid=1 next cycle, press_code := index of set bit; else err path (REQ-024); both -> HELD.
REQ-015 Code mapping: sw[0]->0, sw[1]->1, sw[2]->2, sw[3]->3.
REQ-016 HELD: ss == 0 -> DB_RELEASE, cnt := 0; else stay; no further pulses while held.
REQ-017 DB_RELEASE: ss != 0 -> HELD; ss == 0 and cnt == DB_CYCLES-1 -> IDLE; else cnt++.
REQ-018 on_off=0 in any state -> HELD next cycle; no press_valid/err pulse in that cycle; switches still up at re-enable must be released and debounced before a new press counts.
REQ-019 Latency: press_valid asserted on the edge DB_CYCLES+2 edges after the edge first sampling a stable one-hot sw from all-zero in IDLE.
REQ-020 press_valid and err SHALL never be high in the same cycle, and each is high for exactly one cycle per press.
REQ-021 cnt width = clog2(DB_CYCLES); cnt SHALL never exceed DB_CYCLES-1 (no wrap).
REQ-022 Glitch shorter than DB_CYCLES in any debounce state SHALL produce no pulse and no state advance beyond the rules above.

Reset
REQ-023 reset=1 -> state HELD, cnt=0, pat=0, synchronizer=0, press_valid=0, press_code=0, err=0, busy=1; reset overrides all other inputs including mid-debounce.

Configuration
REQ-024 Macro SW_MULTI_PRESS_ERR_EN defined: non-one-hot debounced pattern -> err=1 for one cycle, then HELD. Undefined: err tied 0, non-one-hot pattern silently -> HELD; port err always present.

Verification
REQ-025 DB_CYCLES=4, reset then sw=0 for 10 cycles, on_off=1, sw=4'b0100 held -> single press_valid 6 edges later, press_code=2, busy=1 until 4+ cycles after release.
REQ-026 DB_CYCLES=4, sw=4'b0001 toggling every 2 cycles for 20 cycles then 0 -> no press_valid, no err.
REQ-027 DB_CYCLES=4, macro defined, sw=4'b0011 held 10 cycles -> err=1 one cycle, press_valid=0; macro undefined -> err stays 0, no press_valid.
REQ-028 DB_CYCLES=4, sw=4'b1000 held across reset and on_off rise -> no press_valid until sw released >=4 cycles and pressed again, then press_code=3.
REQ-029 DB_CYCLES=4, on_off dropped in DB_PRESS at cnt=2 -> no pulse, state HELD; reset asserted in HELD -> all outputs at REQ-023 values next cycle.
